// File: rtl/floo_vc_credit_receiver_pkg.sv
// Shared types and width helpers for the VC credit receiver slice.
// Width helper keeps single-VC / single-slot configurations at a legal 1-bit index.
package floo_vc_credit_receiver_pkg;

   typedef enum logic [2:0] {
      North = 3'd0,
      East  = 3'd1,
      South = 3'd2,
      West  = 3'd3,
      Eject = 3'd4
   } route_direction_e;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/floo_vc_credit_receiver_if.sv
// Link-side and allocator-side signals of one router input port.
// slave: the receiver; master: the upstream link plus local switch allocation.
interface floo_vc_credit_receiver_if
   import floo_vc_credit_receiver_pkg::*;
#(
   parameter int unsigned NumVC      = 4,
   parameter int unsigned NumVCWidth = idx_width(NumVC),
   parameter type         flit_t     = logic
) ();

   logic                    data_v_i;
   flit_t                   data_i;
   logic [NumVCWidth-1:0]   vc_id_i;
   logic [NumVC-1:0]        vc_v_o;
   flit_t [NumVC-1:0]       vc_data_o;
   logic [NumVC-1:0]        read_oh_i;
   logic                    credit_v_o;
   logic [NumVCWidth-1:0]   credit_id_o;
   logic                    overflow_o;

   modport slave (
      input  data_v_i, data_i, vc_id_i, read_oh_i,
      output vc_v_o, vc_data_o, credit_v_o, credit_id_o, overflow_o
   );

   modport master (
      output data_v_i, data_i, vc_id_i, read_oh_i,
      input  vc_v_o, vc_data_o, credit_v_o, credit_id_o, overflow_o
   );

endinterface

// File: rtl/floo_vc_credit_receiver_fifo.sv
// Per-VC flit FIFO, no fall-through: a push is visible on rdata the cycle after.
// Push on full and pop on empty are ignored; fullness uses the pre-pop occupancy.
module floo_vc_credit_receiver_fifo
   import floo_vc_credit_receiver_pkg::*;
#(
   parameter int unsigned Depth = 2,
   parameter type         dtype = logic
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic push,
   input  dtype wdata,
   input  logic pop,
   output dtype rdata,
   output logic full,
   output logic empty
);

   localparam int unsigned PtrW = idx_width(Depth);
   localparam int unsigned CntW = $clog2(Depth + 1);

   dtype [Depth-1:0] mem_q;
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  cnt_q;
   logic             push_ok, pop_ok;

   function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
      return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt_q == CntW'(Depth));
   assign empty   = (cnt_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign rdata   = mem_q[rd_ptr_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= next_ptr(wr_ptr_q);
         end
         if (pop_ok) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/floo_vc_credit_receiver.sv
// Receiving end of the VC credit protocol: demuxes link flits into per-VC FIFOs,
// shows per-VC heads to switch allocation and returns one credit per dequeued flit.
module floo_vc_credit_receiver
   import floo_vc_credit_receiver_pkg::*;
#(
   parameter int unsigned NumVC          = 4,
   parameter int unsigned NumVCWidth     = idx_width(NumVC),
   parameter int unsigned VCDepth        = 2,
   parameter bit          CreditShortcut = 1'b0,
   parameter bit          OverflowAssert = 1'b1,
   parameter type         flit_t         = logic
) (
   input logic                      clk_i,
   input logic                      rst_ni,
   floo_vc_credit_receiver_if.slave bus
);

   typedef struct packed {
      logic                  v;
      logic [NumVCWidth-1:0] id;
   } vc_credit_t;

   logic [NumVC-1:0]      push_req, pop_req, full, empty;
   flit_t [NumVC-1:0]     head;
   logic [NumVCWidth-1:0] wr_sel, rd_idx;
   logic                  id_ok, rd_any, rd_ok, overflow_set, overflow_q;
   vc_credit_t            credit_d, credit_q;

   // A single-VC port ignores the id field entirely.
   assign wr_sel = (NumVC == 1) ? '0 : bus.vc_id_i;
   assign id_ok  = (NumVC == 1) || ({1'b0, bus.vc_id_i} < (NumVCWidth + 1)'(NumVC));

   // Lowest set bit wins if allocation ever asserts more than one strobe.
   always_comb begin
      rd_idx = '0;
      for (int k = int'(NumVC) - 1; k >= 0; k--) begin
         if (bus.read_oh_i[k]) rd_idx = NumVCWidth'(k);
      end
   end

   assign rd_any = |bus.read_oh_i;
   assign rd_ok  = rd_any & ~empty[rd_idx];

   for (genvar k = 0; k < NumVC; k++) begin : g_vc
      assign push_req[k] = bus.data_v_i & id_ok & (wr_sel == NumVCWidth'(k));
      assign pop_req[k]  = rd_any & (rd_idx == NumVCWidth'(k));

      floo_vc_credit_receiver_fifo #(
         .Depth (VCDepth),
         .dtype (flit_t)
      ) i_fifo (
         .clk_i  (clk_i),
         .rst_ni (rst_ni),
         .push   (push_req[k]),
         .wdata  (bus.data_i),
         .pop    (pop_req[k]),
         .rdata  (head[k]),
         .full   (full[k]),
         .empty  (empty[k])
      );
   end

   always_comb begin
      bus.vc_v_o = ~empty;
      for (int k = 0; k < int'(NumVC); k++) begin
         bus.vc_data_o[k] = empty[k] ? '0 : head[k];
      end
   end

   // Full is judged before this cycle's pop, so a same-cycle pop never rescues a write.
   assign overflow_set = bus.data_v_i & (~id_ok | (|(push_req & full)));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) overflow_q <= 1'b0;
      else if (overflow_set) overflow_q <= 1'b1;
   end

   assign bus.overflow_o = overflow_q;

   always_comb begin
      credit_d.v  = rd_ok;
      credit_d.id = rd_ok ? rd_idx : credit_q.id;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) credit_q <= '0;
      else         credit_q <= credit_d;
   end

   assign bus.credit_v_o  = CreditShortcut ? credit_d.v  : credit_q.v;
   assign bus.credit_id_o = CreditShortcut ? credit_d.id : credit_q.id;

   read_onehot_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
      $onehot0(bus.read_oh_i));

   no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni || !OverflowAssert)
      !overflow_set);

endmodule

// File: tb/tb_floo_vc_credit_receiver.sv
// Directed checks on a 4x2 receiver with registered credits, then random credit-driven
// traffic on a 4x3 receiver with shortcut credits against a per-VC queue model.
module tb_floo_vc_credit_receiver;

   typedef logic [15:0] tb_flit_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   floo_vc_credit_receiver_if #(.NumVC(4), .NumVCWidth(2), .flit_t(tb_flit_t)) if_a ();
   floo_vc_credit_receiver_if #(.NumVC(4), .NumVCWidth(2), .flit_t(tb_flit_t)) if_b ();

   floo_vc_credit_receiver #(
      .NumVC(4), .NumVCWidth(2), .VCDepth(2), .CreditShortcut(1'b0),
      .OverflowAssert(1'b0), .flit_t(tb_flit_t)
   ) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .bus(if_a.slave)
   );

   floo_vc_credit_receiver #(
      .NumVC(4), .NumVCWidth(2), .VCDepth(3), .CreditShortcut(1'b1),
      .OverflowAssert(1'b1), .flit_t(tb_flit_t)
   ) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .bus(if_b.slave)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [1:0] id, input tb_flit_t d,
                          input logic [3:0] rd);
      if_a.data_v_i  = v;
      if_a.vc_id_i   = id;
      if_a.data_i    = d;
      if_a.read_oh_i = rd;
   endtask

   tb_flit_t q[4][$];
   int       up_credit[4];
   int       popped[4];
   int       credited[4];

   initial begin
      drive_a(1'b0, 2'd0, '0, 4'b0000);
      if_b.data_v_i = 1'b0; if_b.vc_id_i = '0; if_b.data_i = '0; if_b.read_oh_i = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: idle after reset
      check("reset_vc_data", 32'(if_a.vc_data_o), 32'h0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         check("idle_vc_v", 32'(if_a.vc_v_o), 32'h0);
         check("idle_credit_v", 32'(if_a.credit_v_o), 32'h0);
         check("idle_overflow", 32'(if_a.overflow_o), 32'h0);
      end

      // 2: A,B into VC2 then two pops
      drive_a(1'b1, 2'd2, 16'hA0A0, 4'b0000); cyc();
      check("t2_vc_v_after_a", 32'(if_a.vc_v_o), 32'h4);
      check("t2_head_a", 32'(if_a.vc_data_o[2]), 32'hA0A0);
      drive_a(1'b1, 2'd2, 16'hB0B0, 4'b0000); cyc();
      check("t2_head_still_a", 32'(if_a.vc_data_o[2]), 32'hA0A0);
      drive_a(1'b0, 2'd0, '0, 4'b0100); cyc();
      check("t2_head_b", 32'(if_a.vc_data_o[2]), 32'hB0B0);
      check("t2_credit1_v", 32'(if_a.credit_v_o), 32'h1);
      check("t2_credit1_id", 32'(if_a.credit_id_o), 32'h2);
      cyc();
      check("t2_vc2_empty", 32'(if_a.vc_v_o), 32'h0);
      check("t2_credit2_v", 32'(if_a.credit_v_o), 32'h1);
      check("t2_credit2_id", 32'(if_a.credit_id_o), 32'h2);
      drive_a(1'b0, 2'd0, '0, 4'b0000); cyc();
      check("t2_credit_off", 32'(if_a.credit_v_o), 32'h0);
      check("t2_credit_id_hold", 32'(if_a.credit_id_o), 32'h2);

      // 3: overflow on full VC1 despite a same-cycle pop
      drive_a(1'b1, 2'd1, 16'hC1C1, 4'b0000); cyc();
      drive_a(1'b1, 2'd1, 16'hD1D1, 4'b0000); cyc();
      check("t3_full_no_ovf", 32'(if_a.overflow_o), 32'h0);
      drive_a(1'b1, 2'd1, 16'hE1E1, 4'b0010); cyc();
      check("t3_overflow", 32'(if_a.overflow_o), 32'h1);
      check("t3_credit_v", 32'(if_a.credit_v_o), 32'h1);
      check("t3_credit_id", 32'(if_a.credit_id_o), 32'h1);
      check("t3_head_d", 32'(if_a.vc_data_o[1]), 32'hD1D1);
      drive_a(1'b0, 2'd0, '0, 4'b0000); cyc();
      check("t3_overflow_sticky", 32'(if_a.overflow_o), 32'h1);
      check("t3_credit_single", 32'(if_a.credit_v_o), 32'h0);
      drive_a(1'b0, 2'd0, '0, 4'b0010); cyc();
      check("t3_one_flit_left", 32'(if_a.vc_v_o), 32'h0);
      check("t3_drain_credit", 32'(if_a.credit_v_o), 32'h1);

      // 4: write VC0 while reading VC3
      drive_a(1'b1, 2'd3, 16'hF3F3, 4'b0000); cyc();
      drive_a(1'b1, 2'd0, 16'h6060, 4'b1000); cyc();
      check("t4_vc_v", 32'(if_a.vc_v_o), 32'h1);
      check("t4_head0", 32'(if_a.vc_data_o[0]), 32'h6060);
      check("t4_vc3_data", 32'(if_a.vc_data_o[3]), 32'h0);
      check("t4_credit_id", 32'(if_a.credit_id_o), 32'h3);
      drive_a(1'b0, 2'd0, '0, 4'b0001); cyc();
      check("t4_credit_id0", 32'(if_a.credit_id_o), 32'h0);

      // 5: read of an empty VC
      drive_a(1'b0, 2'd0, '0, 4'b0010); cyc();
      check("t5_no_credit", 32'(if_a.credit_v_o), 32'h0);
      check("t5_id_hold", 32'(if_a.credit_id_o), 32'h0);
      check("t5_vc_v", 32'(if_a.vc_v_o), 32'h0);

      // write+read on the same empty VC: write lands, read ignored
      drive_a(1'b1, 2'd2, 16'h4242, 4'b0100); cyc();
      check("wr_rd_empty_vc_v", 32'(if_a.vc_v_o), 32'h4);
      check("wr_rd_empty_head", 32'(if_a.vc_data_o[2]), 32'h4242);
      check("wr_rd_empty_credit", 32'(if_a.credit_v_o), 32'h0);
      drive_a(1'b0, 2'd0, '0, 4'b0100); cyc();

      // reset mid-operation drops contents and a pending credit
      drive_a(1'b1, 2'd0, 16'h7777, 4'b0000); cyc();
      drive_a(1'b1, 2'd1, 16'h8888, 4'b0001); cyc();
      rst_n = 1'b0;
      #1;
      check("mid_rst_vc_v", 32'(if_a.vc_v_o), 32'h0);
      check("mid_rst_credit_v", 32'(if_a.credit_v_o), 32'h0);
      check("mid_rst_credit_id", 32'(if_a.credit_id_o), 32'h0);
      check("mid_rst_overflow", 32'(if_a.overflow_o), 32'h0);
      drive_a(1'b0, 2'd0, '0, 4'b0000);
      @(negedge clk);
      rst_n = 1'b1;
      cyc();

      // 6: random credit-driven traffic on the 4x3 receiver
      for (int k = 0; k < 4; k++) begin
         up_credit[k] = 3;
         popped[k]    = 0;
         credited[k]  = 0;
      end
      for (int cycle = 0; cycle < 10000; cycle++) begin
         logic [3:0] exp_v;
         int         wk, rk;
         logic       do_wr, do_pop;
         tb_flit_t   wd;
         exp_v = '0;
         for (int k = 0; k < 4; k++) exp_v[k] = (q[k].size() != 0);
         check("rnd_vc_v", 32'(if_b.vc_v_o), 32'(exp_v));
         for (int k = 0; k < 4; k++) begin
            if (q[k].size() != 0) check("rnd_head", 32'(if_b.vc_data_o[k]), 32'(q[k][0]));
         end
         check("rnd_overflow", 32'(if_b.overflow_o), 32'h0);

         wk    = int'($urandom_range(0, 3));
         do_wr = ($urandom_range(0, 3) != 0) && (up_credit[wk] > 0);
         wd    = tb_flit_t'($urandom);
         rk    = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 3));
         do_pop = (rk >= 0) && (q[rk].size() != 0);

         if_b.data_v_i  = do_wr;
         if_b.vc_id_i   = 2'(wk);
         if_b.data_i    = wd;
         if_b.read_oh_i = (rk >= 0) ? (4'b0001 << rk) : 4'b0000;
         #1;
         check("rnd_credit_v", 32'(if_b.credit_v_o), 32'(do_pop));
         if (do_pop) check("rnd_credit_id", 32'(if_b.credit_id_o), 32'(rk));
         if (if_b.credit_v_o) credited[if_b.credit_id_o]++;

         if (do_pop) begin
            void'(q[rk].pop_front());
            popped[rk]++;
            up_credit[rk]++;
         end
         if (do_wr) begin
            q[wk].push_back(wd);
            up_credit[wk]--;
         end
         @(posedge clk);
         #1;
      end
      if_b.data_v_i = 1'b0;
      if_b.read_oh_i = '0;
      for (int k = 0; k < 4; k++) begin
         check("rnd_credit_total", 32'(credited[k]), 32'(popped[k]));
      end
      check("rnd_final_overflow", 32'(if_b.overflow_o), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
